// File: rtl/rx_unit.sv
// rx_unit: 8N1 serial receiver for the MiniUart.
// Synchronises rxd and oversamples it with the en_rx tick, OSR ticks per bit.
// It confirms the start bit at half a bit time, then samples the 8 data bits
// (LSB first) and the stop bit one bit time apart, near each bit centre.
// Completed bytes go to d_out together with the rs/fe/oe status flags.
module rx_unit #(
  parameter int OSR = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       en_rx,
  input  logic       clr_rs,
  output logic [7:0] d_out,
  output logic       rs,
  output logic       fe,
  output logic       oe
);

  localparam int SW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(OSR - 1);
  localparam logic [SW-1:0] SUB_MID  = SW'(OSR / 2 - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;

  logic [1:0]    sync_q;
  logic          rxd_s;
  logic [2:0]    state;
  logic [SW-1:0] sub;
  logic [2:0]    bitn;
  logic [7:0]    sreg;
  logic          done;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], rxd};
  end

  assign rxd_s = sync_q[1];

  // Stop-bit sample tick: the frame completes on this edge
  assign done = en_rx && (state == S_STOP) && (sub == SUB_LAST);

  // Frame FSM, tick counter and shift register; everything frozen without en_rx
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      sub   <= '0;
      bitn  <= '0;
      sreg  <= '0;
    end else if (en_rx) begin
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state <= S_START;
            sub   <= '0;
          end
        end
        S_START: begin
          // Re-check the line half a bit in; a high line was only a glitch
          if (sub == SUB_MID) begin
            if (!rxd_s) begin
              state <= S_DATA;
              sub   <= '0;
              bitn  <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            sub <= sub + SW'(1);
          end
        end
        S_DATA: begin
          if (sub == SUB_LAST) begin
            sreg <= {rxd_s, sreg[7:1]};
            sub  <= '0;
            bitn <= bitn + 3'd1;
            if (bitn == 3'd7) state <= S_STOP;
          end else begin
            sub <= sub + SW'(1);
          end
        end
        S_STOP: begin
          if (sub == SUB_LAST) begin
            sub   <= '0;
            // A low stop bit may be a break: wait for the line to recover
            state <= rxd_s ? S_IDLE : S_WAIT_HI;
          end else begin
            sub <= sub + SW'(1);
          end
        end
        S_WAIT_HI: begin
          if (rxd_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output register and flags; completion takes priority over a read acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out <= '0;
      rs    <= 1'b0;
      fe    <= 1'b0;
      oe    <= 1'b0;
    end else if (done) begin
      d_out <= sreg;
      rs    <= 1'b1;
      fe    <= ~rxd_s;
      if (rs && !clr_rs) oe <= 1'b1;
    end else if (clr_rs) begin
      rs <= 1'b0;
      fe <= 1'b0;
      oe <= 1'b0;
    end
  end

endmodule
